// File: rtl/jiajian_seq.sv
// jiajian_seq: add / subtract / accumulate / clear unit with a 2-entry result FIFO.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operation handshake; a, b, sl are sampled on accept
//   a, b [W-1:0]      unsigned operands
//   sl [1:0]          opcode: 00 add, 11 subtract, 01 accumulate, 10 clear acc
//   out_valid/out_ready result handshake
//   c [W:0], flag     head-of-FIFO result and its carry/borrow/saturation bit
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on the registered FIFO count (and rst), never
// on out_ready. out_valid, c and flag come straight from registers and stay
// stable while out_valid & ~out_ready.
module jiajian_seq #(
  parameter int W   = 6,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   sl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   c,
  output logic         flag
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ACC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  logic [1:0]   count;
  logic [W:0]   acc;
  // Entry 0 is always the head; entry 1 is only meaningful when count == 2.
  logic [W:0]   e0_c, e1_c;
  logic         e0_f, e1_f;

  logic         accept, pop;
  logic [W:0]   res_c;
  logic         res_f;
  logic [W:0]   acc_nxt;
  logic [W+1:0] acc_wide;

  assign in_ready  = (count != 2'd2) & ~rst;
  assign out_valid = (count != 2'd0);
  assign c         = e0_c;
  assign flag      = e0_f;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Result of the offered operation and the accumulator value it would leave.
  always_comb begin
    res_c    = '0;
    res_f    = 1'b0;
    acc_nxt  = acc;
    acc_wide = {1'b0, acc} + {2'b00, a};
    case (sl)
      OP_ADD: begin
        res_c = {1'b0, a} + {1'b0, b};
        res_f = 1'b0;
      end
      OP_SUB: begin
        res_c = {1'b0, a} - {1'b0, b};
        res_f = (a < b);
      end
      OP_ACC: begin
        if (SAT) begin
          // Any carry into bit W+1 means the true sum exceeds the W+1-bit range.
          acc_nxt = acc_wide[W+1] ? {(W+1){1'b1}} : acc_wide[W:0];
          res_f   = acc_wide[W+1];
        end else begin
          acc_nxt = acc_wide[W:0];
          res_f   = acc_wide[W+1];
        end
        res_c = acc_nxt;
      end
      OP_CLR: begin
        acc_nxt = '0;
        res_c   = '0;
        res_f   = 1'b0;
      end
      default: begin
        res_c = '0;
        res_f = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      acc   <= '0;
      e0_c  <= '0;
      e0_f  <= 1'b0;
      e1_c  <= '0;
      e1_f  <= 1'b0;
    end else begin
      // acc_nxt equals acc for add/subtract, so acc only moves on 01/10.
      if (accept) acc <= acc_nxt;

      case ({accept, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) begin
            e0_c <= res_c;
            e0_f <= res_f;
          end else begin
            e1_c <= res_c;
            e1_f <= res_f;
          end
        end
        2'b01: begin
          count <= count - 2'd1;
          e0_c  <= e1_c;
          e0_f  <= e1_f;
          e1_c  <= '0;
          e1_f  <= 1'b0;
        end
        2'b11: begin
          // Accept needs count < 2 and pop needs count > 0, so count is 1:
          // the new result replaces the departing head.
          e0_c <= res_c;
          e0_f <= res_f;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jiajian_seq.sv
// Bench for jiajian_seq: one wrapping (SAT=0) and one saturating (SAT=1)
// instance share all inputs; each has its own expected-result queue.
module tb_jiajian_seq;
  localparam int W  = 6;
  localparam int RW = W + 2;   // {flag, c}

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] ACC = 2'b01;
  localparam logic [1:0] CLR = 2'b10;
  localparam logic [1:0] SUB = 2'b11;

  logic         clk, rst, in_valid, out_ready;
  logic [W-1:0] a, b;
  logic [1:0]   sl;
  logic         ir0, ov0, f0, ir1, ov1, f1;
  logic [W:0]   c0, c1;

  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];
  int n_cmp = 0;
  int n_err = 0;

  jiajian_seq #(.W(W), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .sl(sl), .out_valid(ov0), .out_ready(out_ready),
    .c(c0), .flag(f0)
  );

  jiajian_seq #(.W(W), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .sl(sl), .out_valid(ov1), .out_ready(out_ready),
    .c(c1), .flag(f1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: offers one op from a negedge, holds it until accepted
  task automatic send(input logic [1:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic [RW-1:0] e_wrap, input logic [RW-1:0] e_sat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_v; sl = op;
    n = 0;
    while (!ir0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
    end else begin
      check("in_ready_match", ir1, ir0);
      exp_q0.push_back(e_wrap);
      exp_q1.push_back(e_sat);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // scoreboard monitors: compare the head whenever a pop is about to happen
  always @(negedge clk) begin
    logic [RW-1:0] e;
    #2;
    if (ov0 && out_ready) begin
      if (exp_q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wrap_unexpected: got c=%0d flag=%0d, required no output", c0, f0);
      end else begin
        e = exp_q0.pop_front();
        check("wrap_c", c0, e[W:0]);
        check("wrap_flag", f0, e[W+1]);
      end
    end
  end

  always @(negedge clk) begin
    logic [RW-1:0] e;
    #2;
    if (ov1 && out_ready) begin
      if (exp_q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sat_unexpected: got c=%0d flag=%0d, required no output", c1, f1);
      end else begin
        e = exp_q1.pop_front();
        check("sat_c", c1, e[W:0]);
        check("sat_flag", f1, e[W+1]);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sl = ADD;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", ov0, 0);
    check("rst_c", c0, 0);
    check("rst_flag", f0, 0);
    check("rst_in_ready", ir0, 0);
    check("rst_sat_out_valid", ov1, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("post_rst_in_ready", ir0, 1);
    check("post_rst_in_ready_sat", ir1, 1);

    // add 63+63 = 126, visible one cycle after accept, for one cycle only
    out_ready = 1'b1;
    send(ADD, 6'd63, 6'd63, {1'b0, 7'd126}, {1'b0, 7'd126});
    @(negedge clk); #1;
    check("add_latency_valid", ov0, 1);
    @(negedge clk); #1;
    check("add_single_valid", ov0, 0);

    // back-to-back directed vectors (accept and pop in the same cycle)
    send(ADD, 6'd0,  6'd0,  {1'b0, 7'd0},   {1'b0, 7'd0});
    send(ADD, 6'd17, 6'd5,  {1'b0, 7'd22},  {1'b0, 7'd22});
    send(SUB, 6'd5,  6'd9,  {1'b1, 7'd124}, {1'b1, 7'd124});
    send(SUB, 6'd9,  6'd5,  {1'b0, 7'd4},   {1'b0, 7'd4});
    send(SUB, 6'd7,  6'd7,  {1'b0, 7'd0},   {1'b0, 7'd0});
    send(SUB, 6'd0,  6'd63, {1'b1, 7'd65},  {1'b1, 7'd65});
    send(CLR, 6'd12, 6'd3,  {1'b0, 7'd0},   {1'b0, 7'd0});
    send(ACC, 6'd63, 6'd0,  {1'b0, 7'd63},  {1'b0, 7'd63});
    send(ACC, 6'd63, 6'd1,  {1'b0, 7'd126}, {1'b0, 7'd126});
    send(ADD, 6'd1,  6'd1,  {1'b0, 7'd2},   {1'b0, 7'd2});     // acc untouched
    send(ACC, 6'd63, 6'd0,  {1'b1, 7'd61},  {1'b1, 7'd127});
    send(ACC, 6'd0,  6'd0,  {1'b0, 7'd61},  {1'b0, 7'd127});
    repeat (4) @(negedge clk);

    // backpressure: two accepted, third waits until one pops
    out_ready = 1'b0;
    send(ADD, 6'd1,  6'd2,  {1'b0, 7'd3},  {1'b0, 7'd3});
    send(ADD, 6'd10, 6'd20, {1'b0, 7'd30}, {1'b0, 7'd30});
    fork
      send(ADD, 6'd40, 6'd23, {1'b0, 7'd63}, {1'b0, 7'd63});
      begin
        repeat (3) begin
          @(negedge clk); #1;
          check("bp_in_ready_low", ir0, 0);
          check("bp_out_valid", ov0, 1);
          check("bp_c_hold", c0, 3);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_in_ready_after_pop", ir0, 1);
        check("bp_second_head", c0, 30);
      end
    join
    repeat (4) @(negedge clk);

    // reset with count=2 and acc=50
    out_ready = 1'b0;
    send(CLR, 6'd0,  6'd0, {1'b0, 7'd0},  {1'b0, 7'd0});
    send(ACC, 6'd50, 6'd0, {1'b0, 7'd50}, {1'b0, 7'd50});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", ov0, 0);
    check("midrst_in_ready", ir0, 1);
    check("midrst_out_valid_sat", ov1, 0);
    exp_q0.delete();
    exp_q1.delete();
    out_ready = 1'b1;
    send(ACC, 6'd1, 6'd0, {1'b0, 7'd1}, {1'b0, 7'd1});

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", exp_q0.size() + exp_q1.size(), 0);
    check("final_idle", ov0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
